// File: rtl/ex_tracker_queued_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_tracker_queued_if
//  Description : Bundle of the ID-side push port, the EX/data-memory
//                observation inputs and the completed-element output of the
//                queued EX tracker. Also defines the trace element layout.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_tracker_queued_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int QUEUE_DEPTH   = 4,
    parameter int COUNTER_WIDTH = 32
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] time_start;
        logic [COUNTER_WIDTH-1:0] time_end;
    } mem_access_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    pc;
        logic                     pass_through;
        logic [COUNTER_WIDTH-1:0] time_start;
        logic [COUNTER_WIDTH-1:0] time_end;
        mem_access_t              mem_access_req;
    } trace_output;

    logic [COUNTER_WIDTH-1:0] counter;
    logic                     id_data_ready;
    trace_output              id_data_i;
    logic                     ex_ready;
    logic                     data_req_i;
    logic [ADDR_WIDTH-1:0]    data_addr_i;
    logic                     data_gnt_i;
    logic                     data_rvalid_i;
    trace_output              ex_data_o;
    logic                     ex_data_ready;
    logic [CNT_W-1:0]         queue_count;
    logic                     overflow_o;

    // Producer / environment side
    modport master (
        output counter, id_data_ready, id_data_i, ex_ready,
               data_req_i, data_addr_i, data_gnt_i, data_rvalid_i,
        input  ex_data_o, ex_data_ready, queue_count, overflow_o
    );

    // Tracker side
    modport slave (
        input  counter, id_data_ready, id_data_i, ex_ready,
               data_req_i, data_addr_i, data_gnt_i, data_rvalid_i,
        output ex_data_o, ex_data_ready, queue_count, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_tracker_queued.sv
`default_nettype none
// ============================================================================
//  Module      : ex_tracker_queued
//  Description : EX-phase trace tracker with an in-order input queue.
//                Time-stamps the EX phase and the data-memory request of each
//                element (optionally the response phase) and forwards
//                pass-through elements untouched, preserving order.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_tracker_queued #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int QUEUE_DEPTH   = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int TRACK_RVALID  = 1
) (
    input  logic               clk,
    input  logic               rst,
    ex_tracker_queued_if.slave bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

    // Same layout as the interface's trace_output
    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] time_start;
        logic [COUNTER_WIDTH-1:0] time_end;
    } mem_access_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    pc;
        logic                     pass_through;
        logic [COUNTER_WIDTH-1:0] time_start;
        logic [COUNTER_WIDTH-1:0] time_end;
        mem_access_t              mem_access_req;
    } trace_t;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_ACTIVE      = 2'd1,
        S_WAIT_GNT    = 2'd2,
        S_WAIT_RVALID = 2'd3
    } state_t;

    // Address and data width are observation-only in this stage
    logic [31:0] unused_dw;
    logic        unused_addr;
    assign unused_dw   = DATA_WIDTH;
    assign unused_addr = ^bus.data_addr_i;

    // ------------------------------------------------------------------
    // Input queue
    // ------------------------------------------------------------------
    trace_t           queue_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic   w_full, w_empty, w_pop, w_push_ok;
    trace_t w_head;

    assign w_full    = (count_q == CNT_W'(QUEUE_DEPTH));
    assign w_empty   = (count_q == '0);
    // A pop in the same cycle frees the slot a full-queue push needs
    assign w_push_ok = bus.id_data_ready && (!w_full || w_pop);
    assign w_head    = queue_q[rd_ptr_q];

    // Queue storage: written at the tail on an accepted push
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            queue_q[wr_ptr_q] <= bus.id_data_i;
        end
    end

    // Queue pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.id_data_ready && !w_push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tracking FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    trace_t work_q, work_d;
    trace_t out_q, out_d;
    logic   first_q, first_d;
    logic   ready_q, ready_d;
    logic   w_granted, w_emit_work;

    // FSM state, working element and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            out_q   <= '0;
            first_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            out_q   <= out_d;
            first_q <= first_d;
            ready_q <= ready_d;
        end
    end

    // Next state, time-stamp capture and emit decision
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        out_d       = out_q;
        first_d     = first_q;
        ready_d     = 1'b0;
        w_pop       = 1'b0;
        w_granted   = 1'b0;
        w_emit_work = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head.pass_through) begin
                        out_d   = w_head;
                        ready_d = 1'b1;
                    end else begin
                        work_d  = w_head;
                        first_d = 1'b1;
                        state_d = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (first_q) begin
                    work_d.time_start = bus.counter;
                    first_d           = 1'b0;
                end
                // A memory request outranks a plain EX completion
                if (bus.data_req_i) begin
                    work_d.mem_access_req.time_start = bus.counter;
                    if (bus.data_gnt_i) begin
                        work_d.mem_access_req.time_end = bus.counter;
                        w_granted                      = 1'b1;
                    end else begin
                        state_d = S_WAIT_GNT;
                    end
                end else if (bus.ex_ready) begin
                    work_d.time_end = bus.counter;
                    w_emit_work     = 1'b1;
                end
            end
            S_WAIT_GNT: begin
                if (bus.data_gnt_i) begin
                    work_d.mem_access_req.time_end = bus.counter;
                    w_granted                      = 1'b1;
                end
            end
            S_WAIT_RVALID: begin
                if (bus.data_rvalid_i) begin
                    work_d.time_end = bus.counter;
                    w_emit_work     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The grant either ends the element or opens the response phase
        if (w_granted) begin
            if (TRACK_RVALID != 0) begin
                state_d = S_WAIT_RVALID;
            end else begin
                work_d.time_end = bus.counter;
                w_emit_work     = 1'b1;
            end
        end

        if (w_emit_work) begin
            out_d   = work_d;
            ready_d = 1'b1;
            state_d = S_IDLE;
        end
    end

    assign bus.ex_data_o     = out_q;
    assign bus.ex_data_ready = ready_q;
    assign bus.queue_count   = count_q;
    assign bus.overflow_o    = overflow_q;

endmodule
`default_nettype wire
